// File: rtl/ram_mmio_pkg.sv
// Shared types and default constants for the RAM + memory-mapped I/O controller.
package ram_mmio_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_IO_BASE = 64;
    localparam int DEF_N_OUT   = 1;
    localparam int DEF_N_IN    = 1;

endpackage

// File: rtl/ram_mmio_array.sv
// Single-port synchronous RAM, read-before-write, registered read port.
module ram_mmio_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Contents are never reset; the controller's sweep clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_mmio_ctrl.sv
// RAM controller with memory-mapped output/input ports, status word and
// a clear sweep after reset or on SOFT_CLR.
module ram_mmio_ctrl
    import ram_mmio_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int IO_BASE = DEF_IO_BASE,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int N_IN    = DEF_N_IN
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [ADDR_W-1:0]       RAM_ADDR,
    input  logic [DATA_W-1:0]       RAM_IN,
    input  logic                    RAM_WEN,
    input  logic                    RAM_REN,
    input  logic                    SOFT_CLR,
    output logic [DATA_W-1:0]       RAM_OUT,
    output logic                    RAM_RVALID,
    output logic                    BUSY,
    output logic [N_OUT*DATA_W-1:0] IO_OUT,
    output logic [N_OUT-1:0]        IO_OUT_STB,
    input  logic [N_IN*DATA_W-1:0]  IO_IN,
    input  logic [N_IN-1:0]         IO_IN_STB
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STAT_A = IO_BASE + N_OUT + N_IN;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    rvalid_q, rvalid_d;
    logic                    src_ram_q, src_ram_d;
    logic [DATA_W-1:0]       io_rd_q, io_rd_d;
    logic [N_OUT*DATA_W-1:0] out_q, out_d;
    logic [N_OUT-1:0]        stb_q, stb_d;
    logic [N_IN*DATA_W-1:0]  hold_q, hold_d;
    logic [N_IN-1:0]         pend_q, pend_d;

    logic [31:0]       addr_w;
    logic              in_ram;
    logic              stat_hit;
    logic [N_OUT-1:0]  out_hit;
    logic [N_IN-1:0]   in_hit;
    logic              rd, wr, clr;
    logic [DATA_W-1:0] io_val;

    logic              arr_re, arr_we;
    logic [IDX_W-1:0]  arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign addr_w = 32'(RAM_ADDR);

    always_comb begin
        in_ram   = addr_w < 32'(DEPTH);
        stat_hit = addr_w == 32'(STAT_A);
        out_hit  = '0;
        in_hit   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_hit[k] = addr_w == 32'(IO_BASE + k);
        end
        for (int j = 0; j < N_IN; j++) begin
            in_hit[j] = addr_w == 32'(IO_BASE + N_OUT + j);
        end
    end

    always_comb begin
        io_val = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (out_hit[k]) io_val = out_q[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < N_IN; j++) begin
            if (in_hit[j]) io_val = hold_q[j*DATA_W +: DATA_W];
        end
        if (stat_hit) io_val[N_IN-1:0] = pend_q;
    end

    assign clr = state_q == ST_CLEAR;
    assign rd  = !clr && RAM_REN;
    assign wr  = !clr && RAM_WEN;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rvalid_d  = rd;
        src_ram_d = src_ram_q;
        io_rd_d   = io_rd_q;
        out_d     = out_q;
        stb_d     = '0;
        hold_d    = hold_q;
        pend_d    = pend_q;

        if (rd) begin
            src_ram_d = in_ram;
            if (!in_ram) io_rd_d = io_val;
        end

        if (wr) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_hit[k]) begin
                    out_d[k*DATA_W +: DATA_W] = RAM_IN;
                    stb_d[k] = 1'b1;
                end
            end
        end

        // A strobe in the same cycle as the clearing read wins.
        for (int j = 0; j < N_IN; j++) begin
            if (rd && in_hit[j]) pend_d[j] = 1'b0;
            if (IO_IN_STB[j]) begin
                hold_d[j*DATA_W +: DATA_W] = IO_IN[j*DATA_W +: DATA_W];
                pend_d[j] = 1'b1;
            end
        end

        case (state_q)
            ST_CLEAR: begin
                if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (SOFT_CLR) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            rvalid_q  <= 1'b0;
            src_ram_q <= 1'b0;
            io_rd_q   <= '0;
            out_q     <= '0;
            stb_q     <= '0;
            hold_q    <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rvalid_q  <= rvalid_d;
            src_ram_q <= src_ram_d;
            io_rd_q   <= io_rd_d;
            out_q     <= out_d;
            stb_q     <= stb_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        arr_re    = rd && in_ram;
        arr_we    = clr || (wr && in_ram);
        arr_addr  = clr ? idx_q : RAM_ADDR[IDX_W-1:0];
        arr_wdata = clr ? '0 : RAM_IN;
    end

    ram_mmio_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (CLK),
        .rst_n (RST_N),
        .re    (arr_re),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign RAM_OUT    = src_ram_q ? arr_rdata : io_rd_q;
    assign RAM_RVALID = rvalid_q;
    assign BUSY       = clr;
    assign IO_OUT     = out_q;
    assign IO_OUT_STB = stb_q;

endmodule

// File: tb/tb_ram_mmio_ctrl.sv
// Scoreboard bench: reads push expected data, a negedge monitor pops on RVALID.
module tb_ram_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ram_addr = '0;
    logic [15:0] ram_in = '0;
    logic        ram_wen = 1'b0;
    logic        ram_ren = 1'b0;
    logic        soft_clr = 1'b0;
    logic [15:0] ram_out;
    logic        ram_rvalid;
    logic        busy;
    logic [31:0] io_out;
    logic [1:0]  io_out_stb;
    logic [15:0] io_in = '0;
    logic [0:0]  io_in_stb = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    ram_mmio_ctrl #(
        .DATA_W (16), .ADDR_W (8), .DEPTH (64),
        .IO_BASE (64), .N_OUT (2), .N_IN (1)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .RAM_ADDR   (ram_addr),
        .RAM_IN     (ram_in),
        .RAM_WEN    (ram_wen),
        .RAM_REN    (ram_ren),
        .SOFT_CLR   (soft_clr),
        .RAM_OUT    (ram_out),
        .RAM_RVALID (ram_rvalid),
        .BUSY       (busy),
        .IO_OUT     (io_out),
        .IO_OUT_STB (io_out_stb),
        .IO_IN      (io_in),
        .IO_IN_STB  (io_in_stb)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(ram_out), 32'hdead_0000);
            end else begin
                chk("ram_out", 32'(ram_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic op(input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic [15:0] exp,
                      input logic s = 1'b0, input logic [15:0] iv = '0);
        @(negedge clk);
        ram_ren   = r;
        ram_wen   = w;
        ram_addr  = a;
        ram_in    = d;
        io_in_stb = s;
        io_in     = iv;
        if (r) exp_q.push_back(exp);
        @(negedge clk);
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        io_in_stb = 1'b0;
        if (r) chk("rvalid_latency", 32'(ram_rvalid), 32'd1);
    endtask

    task automatic count_busy(input string nm);
        int   n = 0;
        logic bad = 1'b0;
        while (busy && n < 200) begin
            n++;
            ram_ren  = 1'b1;
            ram_wen  = 1'b1;
            soft_clr = 1'b1;
            ram_addr = 8'(n % 72);
            ram_in   = 16'h5555;
            @(negedge clk);
            if (io_out_stb !== 2'b00) bad = 1'b1;
        end
        ram_ren  = 1'b0;
        ram_wen  = 1'b0;
        soft_clr = 1'b0;
        chk(nm, 32'(n), 32'd64);
        chk({nm, "_stb"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ram_out", 32'(ram_out), 32'd0);
        chk("rst_rvalid", 32'(ram_rvalid), 32'd0);
        chk("rst_io_out", io_out, 32'd0);
        chk("rst_stb", 32'(io_out_stb), 32'd0);
        rst_n = 1'b1;
        count_busy("busy_after_reset");

        op(1, 0, 8'd5, 16'h0, 16'h0000);
        op(0, 1, 8'd10, 16'hBEEF, 16'h0);
        op(1, 0, 8'd10, 16'h0, 16'hBEEF);
        op(1, 1, 8'd10, 16'h1234, 16'hBEEF);
        op(1, 0, 8'd10, 16'h0, 16'h1234);

        op(0, 1, 8'd64, 16'h00A5, 16'h0);
        chk("io_out0", 32'(io_out[15:0]), 32'h00A5);
        chk("stb_pulse0", 32'(io_out_stb), 32'd1);
        @(negedge clk);
        chk("stb_drop0", 32'(io_out_stb), 32'd0);
        op(1, 0, 8'd64, 16'h0, 16'h00A5);
        op(0, 1, 8'd65, 16'h1111, 16'h0);
        chk("stb_pulse1", 32'(io_out_stb), 32'd2);
        op(0, 1, 8'd70, 16'hFFFF, 16'h0);
        op(0, 1, 8'd66, 16'hFFFF, 16'h0);
        op(0, 1, 8'd67, 16'hFFFF, 16'h0);
        chk("unmapped_stb", 32'(io_out_stb), 32'd0);
        chk("unmapped_io", io_out, 32'h1111_00A5);
        op(1, 0, 8'd70, 16'h0, 16'h0000);
        op(1, 0, 8'd67, 16'h0, 16'h0000);

        op(0, 0, 8'd0, 16'h0, 16'h0, 1'b1, 16'h0042);
        op(1, 0, 8'd67, 16'h0, 16'h0001);
        op(1, 0, 8'd66, 16'h0, 16'h0042);
        op(1, 0, 8'd67, 16'h0, 16'h0000);
        op(1, 0, 8'd66, 16'h0, 16'h0042, 1'b1, 16'h0043);
        op(1, 0, 8'd67, 16'h0, 16'h0001);
        op(1, 0, 8'd66, 16'h0, 16'h0043);

        op(0, 1, 8'd0, 16'h7777, 16'h0);
        op(0, 1, 8'd63, 16'h8888, 16'h0);
        op(1, 0, 8'd63, 16'h0, 16'h8888);
        @(negedge clk);
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        count_busy("busy_soft_clr");
        chk("io_kept", io_out, 32'h1111_00A5);
        op(1, 0, 8'd0, 16'h0, 16'h0000);
        op(1, 0, 8'd10, 16'h0, 16'h0000);
        op(1, 0, 8'd20, 16'h0, 16'h0000);
        op(1, 0, 8'd63, 16'h0, 16'h0000);

        op(0, 1, 8'd12, 16'hABCD, 16'h0);
        @(negedge clk);
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_io", io_out, 32'd0);
        rst_n = 1'b1;
        count_busy("busy_restart");
        op(1, 0, 8'd12, 16'h0, 16'h0000);
        op(1, 0, 8'd67, 16'h0, 16'h0000);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_mmio_ctrl.md
RAM_MMIO_CTRL -- requirements
Module: ram_mmio_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width.
REQ-002 SHALL have parameter ADDR_W, default 8: address width.
REQ-003 SHALL have parameter DEPTH, default 64: RAM words, with DEPTH <= IO_BASE.
REQ-004 SHALL have parameter IO_BASE, default 64: first I/O address.
REQ-005 SHALL have parameters N_OUT, default 1, and N_IN, default 1: output/input port counts, each 1..8.
REQ-006 SHALL have port CLK  in  1: single clock, all logic on rising edge.
REQ-007 SHALL have port RST_N  in  1: reset, asynchronous, active-low.
REQ-008 SHALL have port RAM_ADDR  in  ADDR_W: access address.
REQ-009 SHALL have port RAM_IN  in  DATA_W: write data.
REQ-010 SHALL have port RAM_WEN  in  1: write request.
REQ-011 SHALL have port RAM_REN  in  1: read request.
REQ-012 SHALL have port SOFT_CLR  in  1: one-cycle pulse requesting a RAM clear.
REQ-013 SHALL have port RAM_OUT  out  DATA_W: registered read data.
REQ-014 SHALL have port RAM_RVALID  out  1: one-cycle pulse, RAM_OUT updated.
REQ-015 SHALL have port BUSY  out  1: clear sweep in progress.
REQ-016 SHALL have port IO_OUT  out  N_OUT*DATA_W: output port registers, port k at bits [k*DATA_W +: DATA_W].
REQ-017 SHALL have port IO_OUT_STB  out  N_OUT: one-cycle pulse per port written.
REQ-018 SHALL have port IO_IN  in  N_IN*DATA_W: input port data.
REQ-019 SHALL have port IO_IN_STB  in  N_IN: capture strobe per input port.

Function
REQ-020 SHALL decode addresses as: 0..DEPTH-1 RAM; IO_BASE+k output port k; IO_BASE+N_OUT+j input port j; IO_BASE+N_OUT+N_IN status; all other addresses unmapped.
REQ-021 SHALL, in IDLE with RAM_REN=1, drive RAM_OUT with the addressed value and pulse RAM_RVALID exactly one cycle later (latency 1); RAM_OUT SHALL hold its value otherwise.
REQ-022 SHALL return output-port readback, input holding register, status (bit j = pending[j], upper bits 0), or 0 when unmapped.
REQ-023 SHALL, in IDLE with RAM_WEN=1, write RAM, or load output port k and pulse IO_OUT_STB[k] the next cycle; writes to input, status or unmapped addresses SHALL be ignored.
REQ-024 SHALL, on RAM_WEN and RAM_REN together at the same address, perform the write and return the pre-write value (read-before-write).
REQ-025 SHALL, on IO_IN_STB[j], latch IO_IN port j into holding register j and set pending[j].
REQ-026 SHALL clear pending[j] on a read of input port j; a simultaneous strobe SHALL win (new value latched, pending stays 1), and the read SHALL return the old value.
REQ-027 SHALL implement FSM states CLEAR and IDLE: CLEAR writes 0 to index 0..DEPTH-1, one word per cycle, then goes to IDLE; IDLE with SOFT_CLR=1 goes to CLEAR with index 0.
REQ-028 SHALL hold BUSY=1 exactly while in CLEAR; RAM_REN, RAM_WEN and SOFT_CLR SHALL be ignored while BUSY (no RVALID, no writes, no strobes); IO_IN_STB capture SHALL continue.
REQ-029 SHALL truncate nothing: address comparisons use the full ADDR_W bits, and the sweep index SHALL be sized $clog2(DEPTH) with no wrap past DEPTH-1.

Reset
REQ-030 SHALL, on RST_N=0, asynchronously set state CLEAR, index 0, BUSY 1, RAM_OUT 0, RAM_RVALID 0, IO_OUT 0, IO_OUT_STB 0, holding registers 0 and pending 0.
REQ-031 SHALL, on reset asserted mid-sweep, restart the sweep from index 0 after release; RAM array SHALL be cleared only by the sweep.

Structure
REQ-032 SHALL place the FSM state enum and default parameter constants in shared package ram_mmio_pkg.
REQ-033 SHALL instantiate one sub-module ram_mmio_array: single-port synchronous RAM, DEPTH x DATA_W, read-before-write.

Verification
REQ-034 SHALL test reset release: BUSY high for exactly 64 cycles; then read of address 5 -> RAM_OUT=0x0000 with RVALID one cycle after REN.
REQ-035 SHALL test a write of 0xBEEF to address 10 followed by a read of 10: RAM_OUT=0xBEEF; same-cycle write of 0x1234 and read of 10 returns 0xBEEF; a subsequent read returns 0x1234.
REQ-036 SHALL test a write of 0x00A5 to address 64 (N_OUT=2): IO_OUT[15:0]=0x00A5 and a 1-cycle IO_OUT_STB=2'b01; a read of 64 returns 0x00A5; a write to 70 (unmapped) changes nothing.
REQ-037 SHALL test IO_IN_STB[0] with IO_IN=0x0042: status=0x0001; a read of input port 0 returns 0x0042 and status becomes 0x0000; a strobe of 0x0043 coincident with the read returns 0x0042 and leaves status 0x0001.
REQ-038 SHALL test SOFT_CLR after writes: BUSY for 64 cycles, REN/WEN ignored during the sweep, all RAM reads afterwards 0; RST_N pulsed low at sweep index 30 restarts a full 64-cycle sweep.
